// File: rtl/opacc_seq.sv
// opacc_seq: command sequencer and initiator for the opacc outer-product
// accumulator. Commands (ZERO, LOAD, MAC, STORE) arrive on a valid/ready port.
// The sequencer then streams vectors into opacc or drains C rows out of
// opacc's shift chain, and pulses done when the command completes.
//
// Handshake rule used on every port (cmd, din, dout): a transfer happens on a
// rising clk edge where valid and ready are both 1. valid never waits on
// ready. ready may depend combinationally on the current state only. On the
// din side, the opacc strobes follow din_valid combinationally in the same
// cycle, so a strobe is issued exactly on the handshake cycle.
module opacc_seq #(
  parameter int NUM_MREGS = 2,
  parameter int XLEN      = 8,
  parameter int vl        = 4,
  parameter int ml        = 4,
  parameter int KMAX      = 16,
  localparam int AW = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1,
  localparam int LW = $clog2(KMAX + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [LW-1:0]      cmd_len,
  // input vector stream
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [ml*XLEN-1:0] din_a,
  input  logic [vl*XLEN-1:0] din_b,
  // output row stream
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [vl*XLEN-1:0] dout_data,
  output logic               dout_last,
  output logic               done,
  // opacc control and data
  output logic               op_c_valid,
  output logic               op_ab_valid,
  output logic [AW-1:0]      op_ci_addr,
  output logic [AW-1:0]      op_ab_addr,
  output logic [ml*XLEN-1:0] op_ai,
  output logic [vl*XLEN-1:0] op_bi,
  output logic [vl*XLEN-1:0] op_ci,
  input  logic [vl*XLEN-1:0] op_co,
  // current FSM state, for observation only
  output logic [2:0]         dbg_state
);

  // Beat counter must cover both a full tile (ml rows) and the longest MAC.
  localparam int BMAX = (ml > KMAX) ? ml : KMAX;
  localparam int CW   = $clog2(BMAX + 1);

  localparam logic [CW-1:0] ML_BEATS = CW'(ml);
  localparam logic [CW-1:0] ML_LAST  = CW'(ml - 1);
  localparam logic [LW-1:0] KMAX_L   = LW'(KMAX);

  localparam logic [1:0] OP_ZERO  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ZERO  = 3'd1,
    S_LOAD  = 3'd2,
    S_MAC   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   len_q, len_d;

  logic            beat;         // one beat of the current command happens this cycle
  logic            beat_last;    // that beat is the final one
  logic [CW-1:0]   beats_total;  // number of beats the current command needs
  logic [LW-1:0]   len_clamped;  // incoming MAC length limited to KMAX

  assign len_clamped = (cmd_len > KMAX_L) ? KMAX_L : cmd_len;

  // MAC runs for the latched K; every other multi-beat command covers one full tile.
  assign beats_total = (state_q == S_MAC) ? CW'(len_q) : ML_BEATS;
  assign beat_last   = beat && (cnt_q == (beats_total - CW'(1)));

  // The latched target register is presented to opacc for the whole command.
  assign op_ci_addr = addr_q;
  assign op_ab_addr = addr_q;
  assign dbg_state  = state_q;

  // Output and strobe decode from the current state and the live handshake inputs.
  always_comb begin
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    dout_data   = '0;
    dout_last   = 1'b0;
    done        = 1'b0;
    op_c_valid  = 1'b0;
    op_ab_valid = 1'b0;
    op_ai       = '0;
    op_bi       = '0;
    op_ci       = '0;
    beat        = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_ZERO: begin
        // Shift zero rows through the whole tile, one per cycle.
        op_c_valid = 1'b1;
        beat       = 1'b1;
      end
      S_LOAD: begin
        din_ready  = 1'b1;
        op_c_valid = din_valid;
        op_ci      = din_b;
        beat       = din_valid;
      end
      S_MAC: begin
        din_ready   = 1'b1;
        op_ab_valid = din_valid;
        op_ai       = din_a;
        op_bi       = din_b;
        beat        = din_valid;
      end
      S_STORE: begin
        // opacc presents row ml-1 combinationally; shifting with zero fill
        // both advances the next row into view and clears the tile.
        dout_valid = 1'b1;
        dout_data  = op_co;
        dout_last  = (cnt_q == ML_LAST);
        op_c_valid = dout_ready;
        beat       = dout_ready;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept commands in IDLE, count beats, finish through DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = len_clamped;
          cnt_d  = '0;
          case (cmd_op)
            OP_ZERO:  state_d = S_ZERO;
            OP_LOAD:  state_d = S_LOAD;
            // A zero-length MAC has nothing to stream and completes at once.
            OP_MAC:   state_d = (len_clamped == '0) ? S_DONE : S_MAC;
            OP_STORE: state_d = S_STORE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_ZERO, S_LOAD, S_MAC, S_STORE: begin
        if (beat_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and command registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_opacc_seq.sv
// Bench for opacc_seq: a small opacc emulator supplies op_co, a command-level
// model predicts every control output each cycle, and a golden tile model
// predicts the rows returned by STORE.
module tb_opacc_seq;

  localparam int NUM_MREGS = 2;
  localparam int XLEN      = 8;
  localparam int VL        = 4;
  localparam int ML        = 4;
  localparam int KMAX      = 16;
  localparam int AW        = 1;
  localparam int LW        = 5;
  localparam int DW        = VL * XLEN;
  localparam int AD        = ML * XLEN;

  localparam logic [1:0] OP_ZERO  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          din_valid, din_ready;
  logic [AD-1:0] din_a;
  logic [DW-1:0] din_b;
  logic          dout_valid, dout_ready, dout_last, done;
  logic [DW-1:0] dout_data;
  logic          op_c_valid, op_ab_valid;
  logic [AW-1:0] op_ci_addr, op_ab_addr;
  logic [AD-1:0] op_ai;
  logic [DW-1:0] op_bi, op_ci, op_co;
  logic [2:0]    dbg_state;

  opacc_seq #(
    .NUM_MREGS(NUM_MREGS), .XLEN(XLEN), .vl(VL), .ml(ML), .KMAX(KMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .din_valid(din_valid), .din_ready(din_ready), .din_a(din_a), .din_b(din_b),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .done(done),
    .op_c_valid(op_c_valid), .op_ab_valid(op_ab_valid),
    .op_ci_addr(op_ci_addr), .op_ab_addr(op_ab_addr),
    .op_ai(op_ai), .op_bi(op_bi), .op_ci(op_ci), .op_co(op_co),
    .dbg_state(dbg_state)
  );

  // ---------------- counters / check helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: cycle bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- opacc emulator (environment) ----------------
  // C shift chain: row r takes row r-1, row 0 takes op_ci; op_co shows row ml-1.
  logic [DW-1:0] emu [NUM_MREGS][ML];
  int n_cstrobe = 0;

  always @(posedge clk) begin
    if (op_c_valid) begin
      for (int r = ML - 1; r > 0; r--) emu[op_ci_addr][r] <= emu[op_ci_addr][r-1];
      emu[op_ci_addr][0] <= op_ci;
      n_cstrobe <= n_cstrobe + 1;
    end
    if (op_ab_valid) begin
      for (int i = 0; i < ML; i++)
        for (int j = 0; j < VL; j++)
          emu[op_ab_addr][i][j*XLEN +: XLEN] <= emu[op_ab_addr][i][j*XLEN +: XLEN]
                                              + op_ai[i*XLEN +: XLEN] * op_bi[j*XLEN +: XLEN];
    end
  end

  assign op_co = emu[op_ci_addr][ML-1];

  // ---------------- golden tiles and scoreboard ----------------
  logic [DW-1:0] gold [NUM_MREGS][ML];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] rows_buf [ML];
  int rd_idx = 0;

  // ---------------- command-level model + per-cycle compare ----------------
  int            m_phase = 0;   // 0 waiting for command, 1 executing, 2 completion cycle
  logic [1:0]    m_op = 2'd0;
  logic [AW-1:0] m_addr = '0;
  int            m_beats = 0;
  int            m_total = 0;
  int            m_k;
  logic          busy, e_cmd_ready, e_din_ready, e_dout_valid, e_dout_last, e_done;
  logic          e_c_valid, e_ab_valid;
  logic [AD-1:0] e_ai;
  logic [DW-1:0] e_bi, e_ci, e_dout;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_phase = 0;
      m_op    = 2'd0;
      m_addr  = '0;
      m_beats = 0;
      m_total = 0;
      rd_idx  = exp_q.size();
    end
    busy         = (m_phase == 1);
    e_cmd_ready  = (m_phase == 0);
    e_done       = (m_phase == 2);
    e_din_ready  = busy && (m_op == OP_LOAD || m_op == OP_MAC);
    e_dout_valid = busy && (m_op == OP_STORE);
    e_dout_last  = e_dout_valid && (m_beats == ML - 1);
    e_c_valid    = busy && ((m_op == OP_ZERO) || (m_op == OP_LOAD && din_valid)
                            || (m_op == OP_STORE && dout_ready));
    e_ab_valid   = busy && (m_op == OP_MAC) && din_valid;
    e_ci         = (busy && m_op == OP_LOAD) ? din_b : '0;
    e_ai         = (busy && m_op == OP_MAC) ? din_a : '0;
    e_bi         = (busy && m_op == OP_MAC) ? din_b : '0;
    e_dout       = e_dout_valid ? op_co : '0;

    chk("cmd_ready", cmd_ready, e_cmd_ready);
    chk("din_ready", din_ready, e_din_ready);
    chk("dout_valid", dout_valid, e_dout_valid);
    chk("dout_last", dout_last, e_dout_last);
    chk("done", done, e_done);
    chk("op_c_valid", op_c_valid, e_c_valid);
    chk("op_ab_valid", op_ab_valid, e_ab_valid);
    chk("op_ci_addr", op_ci_addr, m_addr);
    chk("op_ab_addr", op_ab_addr, m_addr);
    chk("op_ci", op_ci, e_ci);
    chk("op_ai", op_ai, e_ai);
    chk("op_bi", op_bi, e_bi);
    chk("dout_data", dout_data, e_dout);

    if (reset_n && dout_valid && dout_ready) begin
      if (rd_idx < exp_q.size()) begin
        chk("store_row", dout_data, exp_q[rd_idx]);
        rd_idx++;
      end else begin
        fail_bound("store_row_unexpected");
      end
      got_q.push_back(dout_data);
    end

    if (reset_n) begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_op    = cmd_op;
          m_addr  = cmd_addr;
          m_k     = (int'(cmd_len) > KMAX) ? KMAX : int'(cmd_len);
          m_total = (cmd_op == OP_MAC) ? m_k : ML;
          m_beats = 0;
          m_phase = (m_total == 0) ? 2 : 1;
        end
        1: begin
          if (e_c_valid || e_ab_valid) m_beats++;
          if (m_beats == m_total) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int addr, input int len, input bit hold);
    int  t;
    bit  acc;
    repeat ($urandom_range(0, 2)) begin
      din_valid = 1'($urandom_range(0, 1));
      din_a     = $urandom;
      din_b     = $urandom;
      cyc();
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr[AW-1:0];
    cmd_len   = len[LW-1:0];
    t = 0;
    while (1) begin
      @(negedge clk);
      acc = cmd_ready;
      cyc();
      if (acc) break;
      if (++t > 50) begin fail_bound("cmd_accept"); break; end
    end
    if (!hold) cmd_valid = 1'b0;
    din_valid = 1'b0;
    din_a     = '0;
    din_b     = '0;
  endtask

  task automatic wait_din();
    int t;
    bit ok;
    t = 0;
    while (1) begin
      @(negedge clk);
      ok = din_ready;
      cyc();
      if (ok) break;
      if (++t > 50) begin fail_bound("din_accept"); break; end
    end
  endtask

  task automatic wait_done();
    int t;
    bit d;
    t = 0;
    while (1) begin
      @(negedge clk);
      d = done;
      cyc();
      if (d) break;
      if (++t > 100) begin fail_bound("done_wait"); break; end
    end
  endtask

  task automatic do_zero(input int addr);
    send_cmd(OP_ZERO, addr, 0, 1'b0);
    for (int r = 0; r < ML; r++) gold[addr][r] = '0;
    wait_done();
  endtask

  // Loads rows_buf[0..ML-1]; the first row sent ends up as tile row ML-1.
  task automatic do_load(input int addr, input bit gaps, input bit hold);
    send_cmd(OP_LOAD, addr, 0, hold);
    for (int k = 0; k < ML; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin din_valid = 1'b0; cyc(); end
      din_valid = 1'b1;
      din_b     = rows_buf[k];
      din_a     = $urandom;
      wait_din();
    end
    din_valid = 1'b0;
    cmd_valid = 1'b0;
    for (int k = 0; k < ML; k++) gold[addr][ML-1-k] = rows_buf[k];
    wait_done();
  endtask

  // pattern=1: a[i]=i*k+1, b[j]=j*k+2 for beat k; otherwise random vectors.
  task automatic do_mac(input int addr, input int len, input bit gaps, input bit pattern);
    int            k;
    logic [AD-1:0] av;
    logic [DW-1:0] bv;
    logic [XLEN-1:0] e, pa, pb;
    k = (len > KMAX) ? KMAX : len;
    send_cmd(OP_MAC, addr, len, 1'b0);
    for (int b = 0; b < k; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin din_valid = 1'b0; cyc(); end
      for (int i = 0; i < ML; i++) av[i*XLEN +: XLEN] = pattern ? 8'(i * b + 1) : 8'($urandom);
      for (int j = 0; j < VL; j++) bv[j*XLEN +: XLEN] = pattern ? 8'(j * b + 2) : 8'($urandom);
      din_valid = 1'b1;
      din_a     = av;
      din_b     = bv;
      wait_din();
      for (int i = 0; i < ML; i++)
        for (int j = 0; j < VL; j++) begin
          e  = gold[addr][i][j*XLEN +: XLEN];
          pa = av[i*XLEN +: XLEN];
          pb = bv[j*XLEN +: XLEN];
          gold[addr][i][j*XLEN +: XLEN] = e + pa * pb;
        end
    end
    din_valid = 1'b0;
    wait_done();
  endtask

  // mode 0: dout_ready 1,0,1,0...; mode 1: random. abort_after>=0 resets mid-store.
  task automatic do_store(input int addr, input int mode, input int abort_after, output int base);
    int hs, c;
    for (int r = 0; r < ML; r++) exp_q.push_back(gold[addr][ML-1-r]);
    for (int r = 0; r < ML; r++) gold[addr][r] = '0;
    base = got_q.size();
    send_cmd(OP_STORE, addr, 0, 1'b0);
    hs = 0;
    c  = 0;
    while (hs < ML) begin
      dout_ready = (mode == 0) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      din_valid  = 1'($urandom_range(0, 1));
      din_a      = $urandom;
      din_b      = $urandom;
      @(negedge clk);
      if (dout_valid && dout_ready) hs++;
      cyc();
      c++;
      if (abort_after >= 0 && hs == abort_after) break;
      if (c > 100) begin fail_bound("store_rows"); break; end
    end
    din_valid = 1'b0;
    if (abort_after >= 0) begin
      dout_ready = 1'b1;
      #1;
      chk("t6_pre_reset_shift", op_c_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_op_c_valid", op_c_valid, 0);
      chk("t6_rst_dout_valid", dout_valid, 0);
      chk("t6_rst_dout_last", dout_last, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_cmd_ready", cmd_ready, 1);
      dout_ready = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("t6_post_cmd_ready", cmd_ready, 1);
      cyc();
    end else begin
      dout_ready = 1'b0;
      wait_done();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int            base, c0, op, addr, len;
    logic [DW-1:0] row;

    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    din_valid = 1'b0; din_a = '0; din_b = '0; dout_ready = 1'b0;
    for (int a = 0; a < NUM_MREGS; a++)
      for (int r = 0; r < ML; r++) gold[a][r] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_op_c_valid", op_c_valid, 0);
    chk("rst_op_ab_valid", op_ab_valid, 0);
    chk("rst_op_ci_addr", op_ci_addr, 0);
    chk("rst_dbg_state", dbg_state, 0);
    reset_n = 1'b1;
    cyc();

    // T1: LOAD addr0 with row k element j = k*j, back-to-back beats
    for (int k = 0; k < ML; k++)
      for (int j = 0; j < VL; j++) rows_buf[k][j*XLEN +: XLEN] = 8'(k * j);
    c0 = n_cstrobe;
    do_load(0, 1'b0, 1'b0);
    chk("t1_c_strobes", n_cstrobe - c0, 4);

    // T2: STORE addr0 with alternating dout_ready; k=0 row comes out first
    do_store(0, 0, -1, base);
    row = got_q[base];     chk("t2_row0", row, 32'h00000000);
    row = got_q[base + 1]; chk("t2_row1", row, 32'h03020100);
    row = got_q[base + 3]; chk("t2_row3", row, 32'h09060300);

    // T3: ZERO addr1, MAC K=4 with known vectors, STORE
    do_zero(1);
    do_mac(1, 4, 1'b0, 1'b1);
    do_store(1, 1, -1, base);
    row = got_q[base];     chk("t3_c3_0", row[7:0], 8'd44);
    chk("t3_c3_3", row[31:24], 8'd188);
    row = got_q[base + 3]; chk("t3_c0_0", row[7:0], 8'd8);

    // T4: MAC with K=0 completes immediately, no data handshake
    send_cmd(OP_MAC, 1, 0, 1'b0);
    din_valid = 1'b1;
    din_a     = $urandom;
    din_b     = $urandom;
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_din_ready", din_ready, 0);
    chk("t4_op_ab_valid", op_ab_valid, 0);
    cyc();
    @(negedge clk);
    chk("t4_cmd_ready", cmd_ready, 1);
    cyc();
    din_valid = 1'b0;

    // T5: cmd_valid held through LOAD; junk din_valid in IDLE and STORE
    for (int k = 0; k < ML; k++) rows_buf[k] = $urandom;
    do_load(1, 1'b1, 1'b1);
    do_store(1, 1, -1, base);

    // T6: reset after two STORE beats, then a normal LOAD/STORE
    for (int k = 0; k < ML; k++) rows_buf[k] = $urandom;
    do_load(0, 1'b1, 1'b0);
    do_store(0, 1, 2, base);
    for (int k = 0; k < ML; k++) rows_buf[k] = $urandom;
    do_load(0, 1'b1, 1'b0);
    do_store(0, 1, -1, base);

    // Random command mix, including MAC lengths beyond KMAX
    repeat (60) begin
      op   = $urandom_range(0, 3);
      addr = $urandom_range(0, NUM_MREGS - 1);
      case (op)
        0: do_zero(addr);
        1: begin
          for (int k = 0; k < ML; k++) rows_buf[k] = $urandom;
          do_load(addr, 1'b1, 1'($urandom_range(0, 1)));
        end
        2: begin
          len = $urandom_range(0, 20);
          do_mac(addr, len, 1'b1, 1'b0);
        end
        default: do_store(addr, $urandom_range(0, 1), -1, base);
      endcase
    end
    for (int a = 0; a < NUM_MREGS; a++) do_store(a, 1, -1, base);

    repeat (2) cyc();
    chk("sb_drained", rd_idx, exp_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
